dcache_ctrl: RTL and testbench

Controller for the data cache in the memory stage (C stage). Sits between the C-stage load/store request and a word-serial main-memory port. It manages a direct-mapped, write-through, no-write-allocate cache. On a load miss it sequences a full line refill. Every store is written through to memory, and the controller stalls the pipeline until memory has accepted it.

---
 rtl/dcache_ctrl_if.sv | 37 +++
 rtl/dcache_ctrl.sv | 151 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - C-stage request, memory port and statistics bundle for dcache_ctrl
interface dcache_ctrl_if;
    logic        req_valid;
    logic        req_is_load;
    logic        req_is_store;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    // Pipeline and memory side: drives requests and memory responses
    modport master (
        output req_valid, req_is_load, req_is_store, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  stall, rd_valid, rd_data,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  hit_count, miss_count
    );

    // Cache controller side
    modport slave (
        input  req_valid, req_is_load, req_is_store, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output stall, rd_valid, rd_data,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output hit_count, miss_count
    );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-write-allocate data cache controller
module dcache_ctrl #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic         clock,
    input  logic         reset,
    dcache_ctrl_if.slave bus
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int WORDS = LINES * WORDS_PER_LINE;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t             r_state;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag_mem [LINES];
    logic [31:0]        r_data_mem [WORDS];
    logic [TAG_W-1:0]   r_tag;
    logic [IDX_W-1:0]   r_idx;
    logic [OFF_W-1:0]   r_cnt;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [31:0]        r_hit_count;
    logic [31:0]        r_miss_count;

    logic [OFF_W-1:0]   w_off;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [OFF_W-1:0]   w_cnt_next;
    logic               w_is_store;
    logic               w_is_load;
    logic               w_line_hit;
    logic               w_idle;
    logic               w_load_hit;
    logic               w_load_miss;
    logic               w_store;
    logic               w_ack;
    logic               w_last;
    logic               w_unused;

    assign w_off       = bus.req_addr[2 +: OFF_W];
    assign w_idx       = bus.req_addr[2 + OFF_W +: IDX_W];
    assign w_tag       = bus.req_addr[31 -: TAG_W];
    assign w_unused    = &{1'b0, bus.req_addr[1:0]};
    assign w_cnt_next  = r_cnt + 1'b1;

    // Store takes priority when both operation flags are set
    assign w_is_store  = bus.req_valid & bus.req_is_store;
    assign w_is_load   = bus.req_valid & bus.req_is_load & ~bus.req_is_store;
    assign w_line_hit  = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag);
    assign w_idle      = (r_state == IDLE);
    assign w_load_hit  = w_idle & w_is_load & w_line_hit;
    assign w_load_miss = w_idle & w_is_load & ~w_line_hit;
    assign w_store     = w_idle & w_is_store;
    // An ack only counts while a transaction is actually outstanding
    assign w_ack       = r_mem_req & bus.mem_ack;
    assign w_last      = &r_cnt;

    // Hits answer in the same cycle; the pipeline is released in the write ack cycle
    assign bus.stall      = (r_state == REFILL) | ((r_state == WRITE) & ~w_ack) |
                            w_load_miss | w_store;
    assign bus.rd_valid   = w_load_hit;
    assign bus.rd_data    = w_load_hit ? r_data_mem[{w_idx, w_off}] : 32'd0;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.hit_count  = r_hit_count;
    assign bus.miss_count = r_miss_count;

    // Controller FSM: line validity, counters and the registered memory request
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_tag        <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_is_store) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
                        r_mem_wdata <= bus.req_wdata;
                        r_state     <= WRITE;
                    end else if (w_is_load) begin
                        if (w_line_hit) begin
                            r_hit_count <= r_hit_count + 32'd1;
                        end else begin
                            r_miss_count   <= r_miss_count + 32'd1;
                            r_valid[w_idx] <= 1'b0;
                            r_tag          <= w_tag;
                            r_idx          <= w_idx;
                            r_cnt          <= '0;
                            r_mem_req      <= 1'b1;
                            r_mem_we       <= 1'b0;
                            r_mem_addr     <= {w_tag, w_idx, {OFF_W{1'b0}}, 2'b00};
                            r_state        <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (w_ack) begin
                        if (w_last) begin
                            r_valid[r_idx] <= 1'b1;
                            r_cnt          <= '0;
                            r_mem_req      <= 1'b0;
                            r_state        <= IDLE;
                        end else begin
                            r_cnt      <= w_cnt_next;
                            r_mem_addr <= {r_tag, r_idx, w_cnt_next, 2'b00};
                        end
                    end
                end
                WRITE: begin
                    if (w_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays: refill words, final tag write, and store-hit updates
    always_ff @(posedge clock) begin
        if ((r_state == REFILL) && w_ack) begin
            r_data_mem[{r_idx, r_cnt}] <= bus.mem_rdata;
            if (w_last) begin
                r_tag_mem[r_idx] <= r_tag;
            end
        end else if (w_store && w_line_hit) begin
            r_data_mem[{w_idx, w_off}] <= bus.req_wdata;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - randomized self-checking bench for dcache_ctrl against a line-residency model
module tb_dcache_ctrl;
    localparam int WPL        = 4;
    localparam int NLINES     = 16;
    localparam int LINE_BYTES = 4 * WPL;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dcache_ctrl_if bus();

    dcache_ctrl #(.LINES(NLINES), .WORDS_PER_LINE(WPL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int ack_wait = 0;
    int resp_waited = 0;

    logic [31:0] phys_mem [logic [31:0]];
    logic [31:0] exp_mem  [logic [31:0]];
    logic [31:0] rd_log [$];
    logic [31:0] wr_log [$];
    int          resident [int];
    logic [31:0] exp_hits   = 32'd0;
    logic [31:0] exp_misses = 32'd0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h3C3C_0000;
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : dflt(a);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int ln;
        int ix;
        ln = int'(a / LINE_BYTES);
        ix = ln % NLINES;
        return resident.exists(ix) && (resident[ix] == ln);
    endfunction

    // Word-serial memory: acks after ack_wait idle cycles, random spurious acks while idle
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        forever begin
            @(posedge clock);
            #1;
            if (!reset && bus.mem_req === 1'b1) begin
                if (resp_waited >= ack_wait) begin
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) begin
                        phys_mem[bus.mem_addr] = bus.mem_wdata;
                        wr_log.push_back(bus.mem_addr);
                        bus.mem_rdata = $urandom;
                    end else begin
                        bus.mem_rdata = phys_rd(bus.mem_addr);
                        rd_log.push_back(bus.mem_addr);
                    end
                    resp_waited = 0;
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                    resp_waited++;
                end
            end else begin
                bus.mem_ack   = reset ? 1'b0 : 1'($urandom_range(0, 1));
                bus.mem_rdata = $urandom;
                resp_waited   = 0;
            end
        end
    end

    task automatic do_load(input logic [31:0] a, output logic [31:0] data, output int cyc);
        logic [31:0] wa;
        bit          hit;
        bit          ok;
        int          ln;
        int          exp_cyc;
        wa  = {a[31:2], 2'b00};
        hit = model_hit(wa);
        ln  = int'(wa / LINE_BYTES);
        exp_cyc = hit ? 0 : 1 + WPL * (ack_wait + 1);
        @(posedge clock);
        #1;
        rd_log.delete();
        bus.req_valid    = 1'b1;
        bus.req_is_load  = 1'b1;
        bus.req_is_store = 1'b0;
        bus.req_addr     = a;
        bus.req_wdata    = $urandom;
        @(negedge clock);
        n_checks++;
        if (bus.stall !== logic'(!hit) || bus.rd_valid !== logic'(hit))
            $display("FAIL load_first_cycle addr=%h stall=%b rd_valid=%b expected stall=%b rd_valid=%b",
                     a, bus.stall, bus.rd_valid, !hit, hit);
        else n_pass++;
        cyc = 0;
        while (bus.stall === 1'b1 && cyc <= 200) begin
            cyc++;
            @(negedge clock);
        end
        n_checks++;
        if (cyc !== exp_cyc)
            $display("FAIL load_latency addr=%h got %0d stall cycles expected %0d", a, cyc, exp_cyc);
        else n_pass++;
        n_checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_rd(wa))
            $display("FAIL load_data addr=%h rd_valid=%b rd_data=%h expected 1 / %h",
                     a, bus.rd_valid, bus.rd_data, exp_rd(wa));
        else n_pass++;
        if (!hit) begin
            ok = (rd_log.size() == WPL);
            for (int i = 0; i < WPL; i++)
                if (i >= rd_log.size() || rd_log[i] !== 32'(ln * LINE_BYTES + 4 * i)) ok = 1'b0;
            n_checks++;
            if (!ok)
                $display("FAIL refill_addrs addr=%h got %0d reads first=%h expected %0d reads from %h",
                         a, rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 32'hx, WPL, ln * LINE_BYTES);
            else n_pass++;
            resident[ln % NLINES] = ln;
            exp_misses++;
        end
        exp_hits++;
        data = bus.rd_data;
        @(posedge clock);
        #1;
        bus.req_valid   = 1'b0;
        bus.req_is_load = 1'b0;
        n_checks++;
        if (bus.hit_count !== exp_hits || bus.miss_count !== exp_misses)
            $display("FAIL load_counters hit=%0d miss=%0d expected hit=%0d miss=%0d",
                     bus.hit_count, bus.miss_count, exp_hits, exp_misses);
        else n_pass++;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int cyc);
        logic [31:0] wa;
        bit          hold_ok;
        wa = {a[31:2], 2'b00};
        @(posedge clock);
        #1;
        wr_log.delete();
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b1;
        bus.req_is_load  = 1'($urandom_range(0, 1));
        bus.req_addr     = a;
        bus.req_wdata    = d;
        @(negedge clock);
        n_checks++;
        if (bus.stall !== 1'b1 || bus.rd_valid !== 1'b0)
            $display("FAIL store_first_cycle addr=%h stall=%b rd_valid=%b expected 1/0", a, bus.stall, bus.rd_valid);
        else n_pass++;
        cyc = 0;
        hold_ok = 1'b1;
        while (bus.stall === 1'b1 && cyc <= 200) begin
            cyc++;
            @(negedge clock);
            if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== wa || bus.mem_wdata !== d)
                hold_ok = 1'b0;
        end
        n_checks++;
        if (!hold_ok || cyc !== 1 + ack_wait)
            $display("FAIL store_write addr=%h hold_ok=%0d stall cycles=%0d expected hold_ok=1 cycles=%0d",
                     a, hold_ok, cyc, 1 + ack_wait);
        else n_pass++;
        exp_mem[wa] = d;
        @(posedge clock);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_is_load  = 1'b0;
        n_checks++;
        if (wr_log.size() != 1 || wr_log[0] !== wa || bus.mem_req !== 1'b0)
            $display("FAIL store_mem_write writes=%0d mem_req=%b expected one write to %h and mem_req=0",
                     wr_log.size(), bus.mem_req, wa);
        else n_pass++;
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_checks++;
        if (bus.stall !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 32'd0)
            $display("FAIL reset_pipe stall=%b rd_valid=%b rd_data=%h expected 0/0/0", bus.stall, bus.rd_valid, bus.rd_data);
        else n_pass++;
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0)
            $display("FAIL reset_mem req=%b we=%b addr=%h wdata=%h expected all 0",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        else n_pass++;
        n_checks++;
        if (bus.hit_count !== 32'd0 || bus.miss_count !== 32'd0)
            $display("FAIL reset_counters hit=%0d miss=%0d expected 0/0", bus.hit_count, bus.miss_count);
        else n_pass++;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_first_refill();
        logic [31:0] d;
        int          c;
        ack_wait = 0;
        do_load(32'h100, d, c);
        n_checks++;
        if (d !== 32'hA0 || c !== 5 || bus.miss_count !== 32'd1 || bus.hit_count !== 32'd1)
            $display("FAIL first_refill data=%h cycles=%0d miss=%0d hit=%0d expected a0/5/1/1",
                     d, c, bus.miss_count, bus.hit_count);
        else n_pass++;
    endtask

    task automatic test_hit();
        logic [31:0] d;
        int          c;
        do_load(32'h108, d, c);
        n_checks++;
        if (d !== 32'hA2 || c !== 0 || bus.hit_count !== 32'd2)
            $display("FAIL hit_0x108 data=%h cycles=%0d hit=%0d expected a2/0/2", d, c, bus.hit_count);
        else n_pass++;
    endtask

    task automatic test_store_hit();
        logic [31:0] d;
        int          c;
        ack_wait = 2;
        do_store(32'h104, 32'hDEADBEEF, c);
        n_checks++;
        if (c !== 3)
            $display("FAIL store_hit_stall cycles=%0d expected 3", c);
        else n_pass++;
        ack_wait = 0;
        do_load(32'h104, d, c);
        n_checks++;
        if (d !== 32'hDEADBEEF || c !== 0)
            $display("FAIL store_hit_reload data=%h cycles=%0d expected deadbeef/0", d, c);
        else n_pass++;
    endtask

    task automatic test_store_miss();
        logic [31:0] d;
        logic [31:0] m0;
        int          c;
        m0 = bus.miss_count;
        do_store(32'h2000, 32'h1234_5678, c);
        do_load(32'h2000, d, c);
        n_checks++;
        if (c !== 5 || d !== 32'h1234_5678 || bus.miss_count !== m0 + 32'd1)
            $display("FAIL store_no_allocate cycles=%0d data=%h miss=%0d expected 5/12345678/%0d",
                     c, d, bus.miss_count, m0 + 32'd1);
        else n_pass++;
    endtask

    task automatic test_conflict();
        logic [31:0] d;
        int          c;
        do_load(32'h100, d, c);
        do_load(32'h500, d, c);
        n_checks++;
        if (c !== 5)
            $display("FAIL conflict_second_load cycles=%0d expected 5", c);
        else n_pass++;
        do_load(32'h100, d, c);
        n_checks++;
        if (c !== 5 || d !== 32'hA0)
            $display("FAIL conflict_reload cycles=%0d data=%h expected 5/a0", c, d);
        else n_pass++;
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] d;
        int          c;
        int          n;
        ack_wait = 0;
        @(posedge clock);
        #1;
        rd_log.delete();
        bus.req_valid    = 1'b1;
        bus.req_is_load  = 1'b1;
        bus.req_is_store = 1'b0;
        bus.req_addr     = 32'h500;
        n = 0;
        while (rd_log.size() < 2 && n < 50) begin
            @(posedge clock);
            #2;
            n++;
        end
        n_checks++;
        if (rd_log.size() < 2)
            $display("FAIL reset_mid_refill_setup reads=%0d expected 2", rd_log.size());
        else n_pass++;
        @(posedge clock);
        #2;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0 || bus.rd_valid !== 1'b0 || bus.miss_count !== 32'd0)
            $display("FAIL reset_mid_refill mem_req=%b stall=%b rd_valid=%b miss=%0d expected 0/0/0/0",
                     bus.mem_req, bus.stall, bus.rd_valid, bus.miss_count);
        else n_pass++;
        @(posedge clock);
        #1;
        reset = 1'b0;
        resident.delete();
        exp_hits   = 32'd0;
        exp_misses = 32'd0;
        do_load(32'h500, d, c);
        n_checks++;
        if (c !== 5 || bus.miss_count !== 32'd1)
            $display("FAIL reset_reissue cycles=%0d miss=%0d expected 5/1", c, bus.miss_count);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] bases [5];
        logic [31:0] a;
        logic [31:0] d;
        int          c;
        bases[0] = 32'h100;
        bases[1] = 32'h500;
        bases[2] = 32'h2000;
        bases[3] = 32'h1040;
        bases[4] = 32'h3F0;
        for (int i = 0; i < 40; i++) begin
            ack_wait = $urandom_range(0, 2);
            a = bases[$urandom_range(0, 4)] + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 7) do_load(a, d, c);
            else do_store(a, $urandom, c);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_is_load  = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        for (int i = 0; i < WPL; i++) begin
            phys_mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
            exp_mem[32'h100 + 32'(4 * i)]  = 32'hA0 + 32'(i);
        end
        test_reset();
        test_first_refill();
        test_hit();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_reset_mid_refill();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
